isp8_bus_responder: RTL and testbench

Synthesizable responder for the isp8 core's external bus, covering both spaces. The memory space is a scratchpad RAM with programmable wait states driven through `ext_mem_ready`. The IO space is a zero-wait register file holding a 16-bit down-counter timer, the interrupt source behind `intr`/`intr_ack`, a scratch register and a test-done register. It connects directly to the core's `ext_*` ports and replaces the bare SPRAM pair in system-level simulation and small SoCs.

---
 rtl/isp8_io_pkg.sv | 25 ++
 rtl/isp8_io_timer.sv | 75 +++++++
 rtl/isp8_bus_responder.sv | 148 ++++++++++++++
 tb/tb_isp8_bus_responder.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/isp8_io_pkg.sv
// Shared constants for the isp8 bus responder: IO register addresses,
// control/status bit positions and the memory handshake state encoding.
package isp8_io_pkg;

    localparam logic [7:0] IO_CTRL    = 8'h00;
    localparam logic [7:0] IO_STATUS  = 8'h01;
    localparam logic [7:0] IO_RLD_LO  = 8'h02;
    localparam logic [7:0] IO_RLD_HI  = 8'h03;
    localparam logic [7:0] IO_CNT_LO  = 8'h04;
    localparam logic [7:0] IO_CNT_HI  = 8'h05;
    localparam logic [7:0] IO_SCRATCH = 8'h06;
    localparam logic [7:0] IO_DONE    = 8'hFF;

    localparam int CTRL_EN     = 0;
    localparam int CTRL_IE     = 1;
    localparam int CTRL_AR     = 2;
    localparam int STATUS_PEND = 0;

    typedef enum logic [1:0] {
        MEM_IDLE,
        MEM_WAIT,
        MEM_DONE
    } mem_state_t;

endpackage

// File: rtl/isp8_io_timer.sv
// 16-bit down-counter timer with auto-reload, pending flag, interrupt
// output and a high-byte snapshot taken when the low byte is read.
module isp8_io_timer
    import isp8_io_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  wdata,
    input  logic        wr_ctrl,
    input  logic        wr_status,
    input  logic        wr_rld_lo,
    input  logic        wr_rld_hi,
    input  logic        rd_cnt_lo,
    input  logic        intr_ack,
    output logic [2:0]  ctrl,
    output logic        pend,
    output logic [15:0] rld,
    output logic [15:0] count,
    output logic [7:0]  snap,
    output logic        intr
);

    logic expire;
    assign expire = ctrl[CTRL_EN] && (count == 16'd0);

    // Control and reload registers; a one-shot expiry drops EN unless
    // software rewrites CTRL on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl <= 3'b000;
            rld  <= 16'h0000;
        end else begin
            if (wr_ctrl)
                ctrl <= wdata[2:0];
            else if (expire && !ctrl[CTRL_AR])
                ctrl[CTRL_EN] <= 1'b0;
            if (wr_rld_lo)
                rld[7:0] <= wdata;
            if (wr_rld_hi)
                rld[15:8] <= wdata;
        end
    end

    // Counter: a high-reload write loads it directly, otherwise count down
    // while enabled and reload on expiry in auto-reload mode.
    always_ff @(posedge clk) begin
        if (rst)
            count <= 16'h0000;
        else if (wr_rld_hi)
            count <= {wdata, rld[7:0]};
        else if (expire) begin
            if (ctrl[CTRL_AR])
                count <= rld;
        end else if (ctrl[CTRL_EN])
            count <= count - 16'd1;
    end

    // Pending flag (expiry beats any clear), snapshot and registered interrupt.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend <= 1'b0;
            snap <= 8'h00;
            intr <= 1'b0;
        end else begin
            if (expire)
                pend <= 1'b1;
            else if (intr_ack || (wr_status && wdata[STATUS_PEND]))
                pend <= 1'b0;
            if (rd_cnt_lo)
                snap <= count[15:8];
            intr <= pend & ctrl[CTRL_IE];
        end
    end

endmodule

// File: rtl/isp8_bus_responder.sv
// Bus responder for the isp8 core: wait-stated scratchpad RAM on the memory
// space and a zero-wait register file (timer, scratch, done) on the IO space.
module isp8_bus_responder
    import isp8_io_pkg::*;
#(
    parameter int MEM_AW      = 5,
    parameter int WAIT_STATES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] ext_addr,
    input  logic [7:0] ext_dout,
    input  logic       ext_mem_wr,
    input  logic       ext_mem_rd,
    input  logic       ext_io_wr,
    input  logic       ext_io_rd,
    input  logic       intr_ack,
    output logic [7:0] ext_mem_din,
    output logic [7:0] ext_io_din,
    output logic       ext_mem_ready,
    output logic       intr,
    output logic       test_done
);

    localparam int DEPTH = 2 ** MEM_AW;

    logic [7:0]        ram [DEPTH];
    logic [MEM_AW-1:0] maddr;
    logic              strobe;
    mem_state_t        state;
    logic [2:0]        wcnt;
    logic              is_wr;

    // Upper address bits are dropped so the scratchpad aliases.
    assign maddr  = ext_addr[MEM_AW-1:0];
    assign strobe = ext_mem_rd | ext_mem_wr;

    // Memory handshake: count wait states, pulse ready for one cycle in DONE,
    // abandon if the core drops its strobe early. Write beats read.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= MEM_IDLE;
            wcnt          <= 3'd0;
            is_wr         <= 1'b0;
            ext_mem_ready <= 1'b0;
            ext_mem_din   <= 8'h00;
        end else begin
            ext_mem_ready <= 1'b0;
            case (state)
                MEM_IDLE: begin
                    if (strobe) begin
                        is_wr <= ext_mem_wr;
                        wcnt  <= 3'(WAIT_STATES);
                        if (WAIT_STATES == 0) begin
                            state         <= MEM_DONE;
                            ext_mem_ready <= 1'b1;
                            if (!ext_mem_wr)
                                ext_mem_din <= ram[maddr];
                        end else begin
                            state <= MEM_WAIT;
                        end
                    end
                end
                MEM_WAIT: begin
                    if (!strobe) begin
                        state <= MEM_IDLE;
                    end else begin
                        wcnt <= wcnt - 3'd1;
                        if (wcnt == 3'd1) begin
                            state         <= MEM_DONE;
                            ext_mem_ready <= 1'b1;
                            if (!is_wr)
                                ext_mem_din <= ram[maddr];
                        end
                    end
                end
                MEM_DONE: state <= MEM_IDLE;
                default:  state <= MEM_IDLE;
            endcase
        end
    end

    // RAM write lands on the edge leaving DONE; reset suppresses it, and the
    // array itself is never cleared.
    always_ff @(posedge clk) begin
        if (!rst && state == MEM_DONE && is_wr)
            ram[maddr] <= ext_dout;
    end

    logic        wr_ctrl, wr_status, wr_rld_lo, wr_rld_hi, rd_cnt_lo;
    logic [2:0]  ctrl;
    logic        pend;
    logic [15:0] rld, count;
    logic [7:0]  snap, scratch;

    assign wr_ctrl   = ext_io_wr && (ext_addr == IO_CTRL);
    assign wr_status = ext_io_wr && (ext_addr == IO_STATUS);
    assign wr_rld_lo = ext_io_wr && (ext_addr == IO_RLD_LO);
    assign wr_rld_hi = ext_io_wr && (ext_addr == IO_RLD_HI);
    assign rd_cnt_lo = ext_io_rd && (ext_addr == IO_CNT_LO);

    isp8_io_timer u_timer (
        .clk       (clk),
        .rst       (rst),
        .wdata     (ext_dout),
        .wr_ctrl   (wr_ctrl),
        .wr_status (wr_status),
        .wr_rld_lo (wr_rld_lo),
        .wr_rld_hi (wr_rld_hi),
        .rd_cnt_lo (rd_cnt_lo),
        .intr_ack  (intr_ack),
        .ctrl      (ctrl),
        .pend      (pend),
        .rld       (rld),
        .count     (count),
        .snap      (snap),
        .intr      (intr)
    );

    // Scratch register and sticky test-done flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            scratch   <= 8'h00;
            test_done <= 1'b0;
        end else begin
            if (ext_io_wr && ext_addr == IO_SCRATCH)
                scratch <= ext_dout;
            if (ext_io_wr && ext_addr == IO_DONE)
                test_done <= 1'b1;
        end
    end

    // IO read mux, decoded straight from the address bus.
    always_comb begin
        ext_io_din = 8'h00;
        case (ext_addr)
            IO_CTRL:    ext_io_din = {5'b00000, ctrl};
            IO_STATUS:  ext_io_din = {7'b0000000, pend};
            IO_RLD_LO:  ext_io_din = rld[7:0];
            IO_RLD_HI:  ext_io_din = rld[15:8];
            IO_CNT_LO:  ext_io_din = count[7:0];
            IO_CNT_HI:  ext_io_din = snap;
            IO_SCRATCH: ext_io_din = scratch;
            default:    ext_io_din = 8'h00;
        endcase
    end

endmodule

// File: tb/tb_isp8_bus_responder.sv
// Self-checking bench: IO register vector table, directed timer/memory
// sequences, and random IO traffic against a register-level reference model.
module tb_isp8_bus_responder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] ext_addr = 8'h00, ext_dout = 8'h00;
    logic       ext_mem_wr = 1'b0, ext_mem_rd = 1'b0;
    logic       ext_io_wr = 1'b0, ext_io_rd = 1'b0, intr_ack = 1'b0;

    logic [7:0] mem_din, io_din, mem_din0, io_din0;
    logic       ready, intr, done, ready0, intr0, done0;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    isp8_bus_responder #(.MEM_AW(5), .WAIT_STATES(2)) dut (
        .clk(clk), .rst(rst), .ext_addr(ext_addr), .ext_dout(ext_dout),
        .ext_mem_wr(ext_mem_wr), .ext_mem_rd(ext_mem_rd),
        .ext_io_wr(ext_io_wr), .ext_io_rd(ext_io_rd), .intr_ack(intr_ack),
        .ext_mem_din(mem_din), .ext_io_din(io_din), .ext_mem_ready(ready),
        .intr(intr), .test_done(done)
    );

    isp8_bus_responder #(.MEM_AW(5), .WAIT_STATES(0)) dut0 (
        .clk(clk), .rst(rst), .ext_addr(ext_addr), .ext_dout(ext_dout),
        .ext_mem_wr(ext_mem_wr), .ext_mem_rd(ext_mem_rd),
        .ext_io_wr(ext_io_wr), .ext_io_rd(ext_io_rd), .intr_ack(intr_ack),
        .ext_mem_din(mem_din0), .ext_io_din(io_din0), .ext_mem_ready(ready0),
        .intr(intr0), .test_done(done0)
    );

    // ---------------- reference model of the IO space ----------------
    logic        m_en, m_ie, m_ar, m_pend, m_intr, m_done;
    logic [15:0] m_rld, m_count;
    logic [7:0]  m_snap, m_scratch;
    logic        m_expire;

    assign m_expire = m_en && (m_count == 16'd0);

    always @(posedge clk) begin
        if (rst) begin
            {m_en, m_ie, m_ar, m_pend, m_intr, m_done} <= 6'b0;
            m_rld <= 16'h0; m_count <= 16'h0; m_snap <= 8'h0; m_scratch <= 8'h0;
        end else begin
            m_intr <= m_pend && m_ie;
            if (ext_io_wr && ext_addr == 8'h00) {m_ar, m_ie, m_en} <= ext_dout[2:0];
            else if (m_expire && !m_ar) m_en <= 1'b0;
            if (m_expire) m_pend <= 1'b1;
            else if (intr_ack || (ext_io_wr && ext_addr == 8'h01 && ext_dout[0])) m_pend <= 1'b0;
            if (ext_io_wr && ext_addr == 8'h02) m_rld[7:0] <= ext_dout;
            if (ext_io_wr && ext_addr == 8'h03) begin
                m_rld[15:8] <= ext_dout;
                m_count <= {ext_dout, m_rld[7:0]};
            end else if (m_en)
                m_count <= (m_count == 16'd0) ? (m_ar ? m_rld : 16'd0) : m_count - 16'd1;
            if (ext_io_rd && ext_addr == 8'h04) m_snap <= m_count[15:8];
            if (ext_io_wr && ext_addr == 8'h06) m_scratch <= ext_dout;
            if (ext_io_wr && ext_addr == 8'hFF) m_done <= 1'b1;
        end
    end

    function automatic logic [7:0] m_read(input logic [7:0] a);
        case (a)
            8'h00:   return {5'b0, m_ar, m_ie, m_en};
            8'h01:   return {7'b0, m_pend};
            8'h02:   return m_rld[7:0];
            8'h03:   return m_rld[15:8];
            8'h04:   return m_count[7:0];
            8'h05:   return m_snap;
            8'h06:   return m_scratch;
            default: return 8'h00;
        endcase
    endfunction

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic io_write(input logic [7:0] a, input logic [7:0] d);
        ext_addr = a; ext_dout = d; ext_io_wr = 1'b1;
        tick();
        ext_io_wr = 1'b0;
    endtask

    task automatic peek(input string name, input logic [7:0] a, input logic [7:0] exp);
        ext_addr = a;
        #1;
        chk(name, io_din, exp);
    endtask

    task automatic mem_access(input bit sel0, input bit wr, input logic [7:0] a,
                              input logic [7:0] d, output int lat, output logic [7:0] rd);
        ext_addr = a; ext_dout = d; ext_mem_wr = wr; ext_mem_rd = !wr;
        lat = 0; rd = 8'h00;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (sel0 ? ready0 : ready) begin
                lat = k;
                rd  = sel0 ? mem_din0 : mem_din;
                break;
            end
        end
        ext_mem_wr = 1'b0; ext_mem_rd = 1'b0;
        tick();
    endtask

    typedef struct {
        bit         wr;
        logic [7:0] addr;
        logic [7:0] data;
        logic [7:0] exp;
    } vec_t;

    vec_t       vecs[17];
    logic [7:0] pool[10];
    logic [7:0] m_ram[32];
    bit         m_known[32];
    int         lat;
    logic [7:0] rdata, pa, a;
    bit         w;

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{1'b1, 8'h06, 8'h5A, 8'h00};
        vecs[1]  = '{1'b0, 8'h06, 8'h00, 8'h5A};
        vecs[2]  = '{1'b1, 8'h02, 8'h12, 8'h00};
        vecs[3]  = '{1'b0, 8'h02, 8'h00, 8'h12};
        vecs[4]  = '{1'b1, 8'h03, 8'h34, 8'h00};
        vecs[5]  = '{1'b0, 8'h03, 8'h00, 8'h34};
        vecs[6]  = '{1'b0, 8'h04, 8'h00, 8'h12};
        vecs[7]  = '{1'b0, 8'h05, 8'h00, 8'h34};
        vecs[8]  = '{1'b1, 8'h00, 8'hF8, 8'h00};
        vecs[9]  = '{1'b0, 8'h00, 8'h00, 8'h00};
        vecs[10] = '{1'b1, 8'h07, 8'hFF, 8'h00};
        vecs[11] = '{1'b0, 8'h07, 8'h00, 8'h00};
        vecs[12] = '{1'b0, 8'hFF, 8'h00, 8'h00};
        vecs[13] = '{1'b0, 8'h01, 8'h00, 8'h00};
        vecs[14] = '{1'b1, 8'h00, 8'h04, 8'h00};
        vecs[15] = '{1'b0, 8'h00, 8'h00, 8'h04};
        vecs[16] = '{1'b1, 8'h00, 8'h00, 8'h00};
        pool = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'hFF, 8'h07, 8'h80};
        for (int i = 0; i < 32; i++) m_known[i] = 1'b0;

        // reset state
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk("rst_ready", ready, 1'b0);
        chk("rst_mem_din", mem_din, 8'h00);
        chk("rst_intr", intr, 1'b0);
        chk("rst_done", done, 1'b0);
        for (int i = 0; i < 7; i++) begin
            a = 8'(i);
            peek("rst_io_reg", a, 8'h00);
        end

        // IO register vector table
        for (int i = 0; i < 17; i++) begin
            ext_addr = vecs[i].addr;
            if (vecs[i].wr) begin
                io_write(vecs[i].addr, vecs[i].data);
            end else begin
                ext_io_rd = 1'b1;
                #1;
                chk("vec_read", io_din, vecs[i].exp);
                tick();
                ext_io_rd = 1'b0;
            end
        end
        chk("vec_done_clear", done, 1'b0);

        // one-shot timer
        io_write(8'h01, 8'h01);
        io_write(8'h02, 8'h05);
        io_write(8'h03, 8'h00);
        io_write(8'h00, 8'h03);
        for (int k = 1; k <= 7; k++) begin
            tick();
            peek("oneshot_pend", 8'h01, (k >= 6) ? 8'h01 : 8'h00);
            chk("oneshot_intr", intr, k >= 7);
        end
        peek("oneshot_en_cleared", 8'h00, 8'h02);
        intr_ack = 1'b1;
        tick();
        intr_ack = 1'b0;
        peek("ack_pend", 8'h01, 8'h00);
        chk("ack_intr_edge", intr, 1'b1);
        tick();
        chk("ack_intr_fall", intr, 1'b0);

        // auto-reload with ack held: expiry and ack coincide on every expiry
        io_write(8'h00, 8'h00);
        io_write(8'h01, 8'h01);
        io_write(8'h02, 8'h03);
        io_write(8'h03, 8'h00);
        io_write(8'h00, 8'h07);
        intr_ack = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            peek("ar_pend", 8'h01, (k % 4 == 0) ? 8'h01 : 8'h00);
            chk("ar_intr", intr, (k >= 5) && (k % 4 == 1));
        end

        // reload of zero in auto-reload mode keeps PEND set every cycle
        io_write(8'h00, 8'h00);
        io_write(8'h02, 8'h00);
        io_write(8'h03, 8'h00);
        io_write(8'h00, 8'h07);
        repeat (3) tick();
        peek("rld0_pend", 8'h01, 8'h01);
        chk("rld0_intr", intr, 1'b1);
        intr_ack = 1'b0;
        io_write(8'h00, 8'h00);
        io_write(8'h01, 8'h01);
        tick();

        // snapshot of high byte at CNT_LO read
        io_write(8'h02, 8'h50);
        io_write(8'h03, 8'h01);
        io_write(8'h00, 8'h01);
        repeat (3) tick();
        ext_addr = 8'h04; ext_io_rd = 1'b1;
        #1;
        chk("snap_cnt_lo", io_din, 8'h4D);
        tick();
        ext_io_rd = 1'b0;
        repeat (8'h60) tick();
        peek("snap_wrapped_lo", 8'h04, 8'hEC);
        peek("snap_cnt_hi", 8'h05, 8'h01);
        io_write(8'h00, 8'h00);

        // sticky test-done
        chk("done_before", done, 1'b0);
        io_write(8'hFF, 8'h00);
        chk("done_set", done, 1'b1);
        repeat (3) tick();
        io_write(8'hFE, 8'h00);
        chk("done_sticky", done, 1'b1);

        // random IO traffic against the model
        for (int i = 0; i < 250; i++) begin
            pa = pool[$urandom_range(0, 9)];
            ext_addr = pa;
            #1;
            chk("rand_io_din", io_din, m_read(pa));
            chk("rand_io_din0", io_din0, m_read(pa));
            chk("rand_intr", intr, m_intr);
            chk("rand_intr0", intr0, m_intr);
            chk("rand_done", done, m_done);
            chk("rand_done0", done0, m_done);
            ext_addr  = pool[$urandom_range(0, 9)];
            ext_io_wr = ($urandom_range(0, 1) == 1);
            ext_io_rd = !ext_io_wr && ($urandom_range(0, 1) == 1);
            ext_dout  = (ext_addr == 8'h03) ? 8'($urandom_range(0, 2)) : 8'($urandom);
            intr_ack  = ($urandom_range(0, 3) == 0);
            tick();
            ext_io_wr = 1'b0; ext_io_rd = 1'b0; intr_ack = 1'b0;
        end

        // memory: WAIT_STATES=2 write/read and aliasing
        mem_access(1'b0, 1'b1, 8'h03, 8'hA5, lat, rdata);
        chk("mem_wr_lat", lat, 3);
        mem_access(1'b0, 1'b0, 8'h03, 8'h00, lat, rdata);
        chk("mem_rd_lat", lat, 3);
        chk("mem_rd_data", rdata, 8'hA5);
        mem_access(1'b0, 1'b1, 8'h23, 8'h3C, lat, rdata);
        mem_access(1'b0, 1'b0, 8'h03, 8'h00, lat, rdata);
        chk("alias_rd_data", rdata, 8'h3C);
        m_ram[3] = 8'h3C; m_known[3] = 1'b1;

        // memory: WAIT_STATES=0 instance (the wait-stated one abandons these)
        mem_access(1'b1, 1'b1, 8'h23, 8'h3C, lat, rdata);
        chk("ws0_wr_lat", lat, 1);
        mem_access(1'b1, 1'b0, 8'h03, 8'h00, lat, rdata);
        chk("ws0_rd_lat", lat, 1);
        chk("ws0_rd_data", rdata, 8'h3C);

        // back-to-back: held read strobe restarts from IDLE after DONE
        ext_addr = 8'h03; ext_mem_rd = 1'b1;
        tick(); chk("b2b_ready1", ready0, 1'b1);
        tick(); chk("b2b_idle", ready0, 1'b0);
        tick(); chk("b2b_ready2", ready0, 1'b1);
        ext_mem_rd = 1'b0;
        repeat (2) tick();

        // abandoned write leaves RAM untouched
        ext_addr = 8'h03; ext_dout = 8'h11; ext_mem_wr = 1'b1;
        tick();
        ext_mem_wr = 1'b0;
        repeat (3) tick();
        mem_access(1'b0, 1'b0, 8'h03, 8'h00, lat, rdata);
        chk("abandon_rd_data", rdata, 8'h3C);

        // random memory traffic on the wait-stated instance
        for (int i = 0; i < 30; i++) begin
            a = 8'($urandom);
            w = ($urandom_range(0, 1) == 1);
            pa = 8'($urandom);
            mem_access(1'b0, w, a, pa, lat, rdata);
            chk("rand_mem_lat", lat, 3);
            if (w) begin
                m_ram[a[4:0]] = pa; m_known[a[4:0]] = 1'b1;
            end else if (m_known[a[4:0]]) begin
                chk("rand_mem_rd", rdata, m_ram[a[4:0]]);
            end
        end

        // reset mid-WAIT aborts a pending write
        mem_access(1'b0, 1'b1, 8'h05, 8'h42, lat, rdata);
        mem_access(1'b0, 1'b0, 8'h05, 8'h00, lat, rdata);
        chk("pre_rst_rd", rdata, 8'h42);
        ext_addr = 8'h05; ext_dout = 8'h77; ext_mem_wr = 1'b1;
        tick();
        rst = 1'b1;
        tick();
        ext_mem_wr = 1'b0;
        chk("midrst_ready", ready, 1'b0);
        chk("midrst_mem_din", mem_din, 8'h00);
        chk("midrst_intr", intr, 1'b0);
        chk("midrst_done", done, 1'b0);
        chk("midrst_done0", done0, 1'b0);
        rst = 1'b0;
        tick();
        peek("midrst_ctrl", 8'h00, m_read(8'h00));
        mem_access(1'b0, 1'b0, 8'h05, 8'h00, lat, rdata);
        chk("midrst_ram_kept", rdata, 8'h42);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
